mmio_bridge_ws: RTL and testbench
=================================

# mmio_bridge_ws

Registered, wait-state-capable successor to the combinational MMIO slot decoder. It sits between the FPRO bus master and up to 64 I/O slots. It latches each bus request and issues a single-cycle strobe to the addressed slot. It then waits for that slot's acknowledge and returns read data with a done/error handshake. Unmapped slots, illegal commands and slots that never acknowledge terminate with an error instead of hanging the bus.

## Interface
- N_SLOTS, 64: number of populated slots, 1..64; slot indices >= N_SLOTS are unmapped.
- REG_AW, 5: register-address field width within a slot.
- DW, 32: data width.
- TIMEOUT, 15: maximum cycles spent waiting for a slot acknowledge, 1..255.
- ERR_DATA, 32'hDEAD_BEEF: value returned on `mmio_rd_data` for errored reads.

Ports:
- clk  in  1  single system clock, all logic on its rising edge.
- rst  in  1  asynchronous, active-low reset: 0 resets all state immediately, independent of clk.
- mmio_cs  in  1  bus request qualifier.
- mmio_rd  in  1  read command.
- mmio_wr  in  1  write command.
- mmio_addr  in  21  bits [REG_AW+5:REG_AW] select the slot; bits [REG_AW-1:0] select the register.
- mmio_wr_data  in  DW  write data.
- mmio_rd_data  out  DW  read data, valid when `mmio_done`=1.
- mmio_busy  out  1  high while a transaction is outstanding.
- mmio_done  out  1  one-cycle completion pulse.
- mmio_err  out  1  qualifies `mmio_done`; 1 means the transaction terminated with an error.
- slot_cs_array  out  N_SLOTS  one-hot slot select strobe.
- slot_mem_rd_array  out  N_SLOTS  read strobe, asserted only on the selected slot.
- slot_mem_wr_array  out  N_SLOTS  write strobe, asserted only on the selected slot.
- slot_reg_addr_array  out  REG_AW x N_SLOTS  latched register address, broadcast to all slots.
- slot_wr_data_array  out  DW x N_SLOTS  latched write data, broadcast to all slots.
- slot_rd_data_array  in  DW x N_SLOTS  slot read data.
- slot_ack_array  in  N_SLOTS  slot acknowledge; a slot with zero wait states ties it high.

## Operation
- FSM states are IDLE, STROBE, WAIT and RESP.
- **IDLE:** a request is accepted when `mmio_cs`=1 and exactly one of `mmio_rd`/`mmio_wr` is 1.
  - On acceptance, latch slot index, register address, write data and command.
  - A mapped slot goes to STROBE.
  - An unmapped slot (index >= N_SLOTS) goes to RESP with error set; no slot strobe is ever issued.
- **Illegal command:** `mmio_cs`=1 with both rd and wr high, in IDLE, goes to RESP with error; no strobe.
- **Ignored in IDLE:** `mmio_cs`=1 with neither rd nor wr is ignored.
- **STROBE:** lasts exactly 1 cycle. `slot_cs_array[sel]` and the matching rd/wr bit are 1; all other bits are 0.
  - If `slot_ack_array[sel]`=1 in this cycle, capture `slot_rd_data_array[sel]` (reads) and go to RESP.
  - Otherwise go to WAIT and clear the timeout counter.
- **WAIT:** strobes are 0.
  - Only `slot_ack_array[sel]` is observed; acks from other slots are ignored.
  - On ack, capture read data and go to RESP.
  - The counter increments each cycle. When it reaches TIMEOUT with no ack, go to RESP with error.
- **RESP:** lasts 1 cycle, drives `mmio_done`=1 and `mmio_err`, then returns to IDLE.
  - Errored reads drive `mmio_rd_data`=ERR_DATA.
  - `mmio_rd_data` holds its last value until the next read completes. Writes leave it unchanged.
- **Busy:** `mmio_busy`=1 in STROBE, WAIT and RESP. Requests presented while busy are ignored, not queued.
- **Timeout counter:** width is clog2(TIMEOUT+1); it saturates and never wraps.
- **Broadcast buses:** the latched register address and write data are held stable on all slots from STROBE through RESP.

## Timing
- **Reset values:** state=IDLE; `mmio_busy`=0, `mmio_done`=0, `mmio_err`=0, `mmio_rd_data`=0; all strobe arrays 0; latched address and data 0; counter 0.
- **Reset mid-transaction:** strobes and done drop asynchronously. The pending transaction is discarded without completion.
- **Zero-wait-state slot:**
  - Request sampled at edge E0; strobe during cycle E0..E1.
  - Done during E1..E2, so `mmio_done` is high 2 cycles after the request.
  - Back-to-back throughput is one transaction every 3 cycles (IDLE, STROBE, RESP).
- **Ack in WAIT:** an ack k cycles after STROBE (k >= 1) gives done 2+k cycles after the request.
- **Timeout:** done+err occurs 2+TIMEOUT cycles after the request.
- **Unmapped slot or illegal command:** done+err occurs 1 cycle after the request.
- **Outputs:** all outputs are registered or decoded directly from registered state; there is no combinational path from mmio_* inputs to outputs.

## Test plan
- **Reset check:** assert rst=0 mid-WAIT -> all outputs reach their reset values immediately; after release, state is IDLE and no done pulse appears.
- **Zero-wait read:** read slot 3, reg 7, with ack tied high and `slot_rd_data_array[3]`=32'h1234_5678.
  - Strobe only on bit 3; `slot_reg_addr_array` entries are 7.
  - Done 2 cycles after the request, with `mmio_rd_data`=32'h1234_5678 and err=0.
- **Wait-state write:** write 32'hA5A5_0001 to slot 10 with ack arriving 4 cycles after STROBE.
  - Write strobe is exactly 1 cycle; write data is held stable throughout.
  - Done at cycle 6 with err=0; `mmio_rd_data` is unchanged.
- **Timeout read:** TIMEOUT=15, slot never acks -> done+err at cycle 17 with `mmio_rd_data`=32'hDEAD_BEEF; next request is accepted normally.
- **Unmapped and illegal:**
  - With N_SLOTS=8, access slot 12 -> no strobe; done+err at cycle 1.
  - rd=wr=1 -> same response.
- **Busy handling:**
  - A second request issued while busy is ignored: there is exactly one strobe and one done.
  - An ack on a non-selected slot during WAIT has no effect.

Source files
------------

// File: rtl/mmio_bridge_ws_if.sv
// Bus bundle between the FPRO master, the mmio_bridge_ws bridge and its I/O slots.
// The slave modport is the bridge; the master modport is everything around it (bus master plus slots).
interface mmio_bridge_ws_if #(
    parameter int N_SLOTS = 64,
    parameter int REG_AW  = 5,
    parameter int DW      = 32
);
    logic                              mmio_cs;
    logic                              mmio_rd;
    logic                              mmio_wr;
    logic [20:0]                       mmio_addr;
    logic [DW-1:0]                     mmio_wr_data;
    logic [DW-1:0]                     mmio_rd_data;
    logic                              mmio_busy;
    logic                              mmio_done;
    logic                              mmio_err;
    logic [N_SLOTS-1:0]                slot_cs_array;
    logic [N_SLOTS-1:0]                slot_mem_rd_array;
    logic [N_SLOTS-1:0]                slot_mem_wr_array;
    logic [N_SLOTS-1:0][REG_AW-1:0]    slot_reg_addr_array;
    logic [N_SLOTS-1:0][DW-1:0]        slot_wr_data_array;
    logic [N_SLOTS-1:0][DW-1:0]        slot_rd_data_array;
    logic [N_SLOTS-1:0]                slot_ack_array;

    modport slave (
        input  mmio_cs, mmio_rd, mmio_wr, mmio_addr, mmio_wr_data,
        output mmio_rd_data, mmio_busy, mmio_done, mmio_err,
        output slot_cs_array, slot_mem_rd_array, slot_mem_wr_array,
        output slot_reg_addr_array, slot_wr_data_array,
        input  slot_rd_data_array, slot_ack_array
    );

    modport master (
        output mmio_cs, mmio_rd, mmio_wr, mmio_addr, mmio_wr_data,
        input  mmio_rd_data, mmio_busy, mmio_done, mmio_err,
        input  slot_cs_array, slot_mem_rd_array, slot_mem_wr_array,
        input  slot_reg_addr_array, slot_wr_data_array,
        output slot_rd_data_array, slot_ack_array
    );
endinterface

// File: rtl/mmio_bridge_ws.sv
// Registered MMIO slot bridge: latches a bus request, strobes one slot for a cycle,
// waits (bounded) for that slot's ack and returns data with a done/err handshake.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// S_IDLE   | waiting for a request; not busy
// S_STROBE | one-cycle strobe to the selected slot; ack may already arrive
// S_WAIT   | strobes low, watching only the selected slot's ack, timeout running
// S_RESP   | one-cycle done pulse with err qualifier, then back to idle
module mmio_bridge_ws #(
    parameter int            N_SLOTS  = 64,
    parameter int            REG_AW   = 5,
    parameter int            DW       = 32,
    parameter int            TIMEOUT  = 15,
    parameter logic [DW-1:0] ERR_DATA = DW'(32'hDEAD_BEEF)
) (
    input logic              clk,
    input logic              rst,
    mmio_bridge_ws_if.slave  bus
);
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {S_IDLE, S_STROBE, S_WAIT, S_RESP} state_e;

    state_e             state_q;
    logic [N_SLOTS-1:0] slot_oh_q;
    logic [N_SLOTS-1:0] cs_strb_q;
    logic [N_SLOTS-1:0] rd_strb_q;
    logic [N_SLOTS-1:0] wr_strb_q;
    logic [REG_AW-1:0]  reg_addr_q;
    logic [DW-1:0]      wr_data_q;
    logic [DW-1:0]      rd_data_q;
    logic               is_rd_q;
    logic               done_q;
    logic               err_q;
    logic [CW-1:0]      cnt_q;

    logic [5:0]         slot_idx_d;
    logic               mapped_d;
    logic [N_SLOTS-1:0] slot_oh_d;
    logic               ack_hit_d;
    logic [DW-1:0]      rd_sel_d;
    logic               unused_addr;

    assign slot_idx_d  = bus.mmio_addr[REG_AW+5:REG_AW];
    assign mapped_d    = (32'(slot_idx_d) < N_SLOTS);
    assign unused_addr = ^bus.mmio_addr[20:REG_AW+6];

    // Ack and read data are qualified by the latched one-hot select, so other slots are ignored.
    always_comb begin
        slot_oh_d = '0;
        rd_sel_d  = '0;
        for (int i = 0; i < N_SLOTS; i++) begin
            if (slot_idx_d == 6'(i)) slot_oh_d[i] = 1'b1;
            if (slot_oh_q[i]) rd_sel_d = rd_sel_d | bus.slot_rd_data_array[i];
        end
        ack_hit_d = |(bus.slot_ack_array & slot_oh_q);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            slot_oh_q  <= '0;
            cs_strb_q  <= '0;
            rd_strb_q  <= '0;
            wr_strb_q  <= '0;
            reg_addr_q <= '0;
            wr_data_q  <= '0;
            rd_data_q  <= '0;
            is_rd_q    <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            cnt_q      <= '0;
        end else begin
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            cs_strb_q <= '0;
            rd_strb_q <= '0;
            wr_strb_q <= '0;
            case (state_q)
                S_IDLE: begin
                    if (bus.mmio_cs && (bus.mmio_rd || bus.mmio_wr)) begin
                        reg_addr_q <= bus.mmio_addr[REG_AW-1:0];
                        wr_data_q  <= bus.mmio_wr_data;
                        is_rd_q    <= bus.mmio_rd;
                        slot_oh_q  <= slot_oh_d;
                        if (bus.mmio_rd && bus.mmio_wr) begin
                            state_q <= S_RESP;
                            done_q  <= 1'b1;
                            err_q   <= 1'b1;
                        end else if (mapped_d) begin
                            state_q   <= S_STROBE;
                            cs_strb_q <= slot_oh_d;
                            rd_strb_q <= bus.mmio_rd ? slot_oh_d : '0;
                            wr_strb_q <= bus.mmio_wr ? slot_oh_d : '0;
                        end else begin
                            state_q <= S_RESP;
                            done_q  <= 1'b1;
                            err_q   <= 1'b1;
                            if (bus.mmio_rd) rd_data_q <= ERR_DATA;
                        end
                    end
                end
                S_STROBE: begin
                    if (ack_hit_d) begin
                        state_q <= S_RESP;
                        done_q  <= 1'b1;
                        if (is_rd_q) rd_data_q <= rd_sel_d;
                    end else begin
                        state_q <= S_WAIT;
                        cnt_q   <= '0;
                    end
                end
                S_WAIT: begin
                    // An ack on the last allowed cycle still wins over the timeout.
                    if (ack_hit_d) begin
                        state_q <= S_RESP;
                        done_q  <= 1'b1;
                        if (is_rd_q) rd_data_q <= rd_sel_d;
                    end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                        state_q <= S_RESP;
                        done_q  <= 1'b1;
                        err_q   <= 1'b1;
                        cnt_q   <= CW'(TIMEOUT);
                        if (is_rd_q) rd_data_q <= ERR_DATA;
                    end else if (cnt_q != CW'(TIMEOUT)) begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_RESP: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.mmio_busy           = (state_q != S_IDLE);
    assign bus.mmio_done           = done_q;
    assign bus.mmio_err            = err_q;
    assign bus.mmio_rd_data        = rd_data_q;
    assign bus.slot_cs_array       = cs_strb_q;
    assign bus.slot_mem_rd_array   = rd_strb_q;
    assign bus.slot_mem_wr_array   = wr_strb_q;
    assign bus.slot_reg_addr_array = {N_SLOTS{reg_addr_q}};
    assign bus.slot_wr_data_array  = {N_SLOTS{wr_data_q}};
endmodule

// File: tb/tb_mmio_bridge_ws.sv
// Self-checking bench for mmio_bridge_ws: transaction-level model of latency, error and read data.
module tb_mmio_bridge_ws;
    localparam int          NS   = 12;
    localparam int          RA   = 5;
    localparam int          DW   = 32;
    localparam int          TO   = 15;
    localparam logic [31:0] ERRD = 32'hDEAD_BEEF;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mmio_bridge_ws_if #(.N_SLOTS(NS), .REG_AW(RA), .DW(DW)) bus ();

    mmio_bridge_ws #(.N_SLOTS(NS), .REG_AW(RA), .DW(DW), .TIMEOUT(TO), .ERR_DATA(ERRD)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int          checks   = 0;
    int          errors   = 0;
    logic [31:0] model_rd = '0;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // cmd: 0 read, 1 write, 2 rd+wr (illegal). dly: ack delay after strobe, <0 never.
    task automatic txn(input int cmd, input int slot, input int regn, input logic [31:0] wdata,
                       input int dly, input bit spam, input bit noise);
        int          exp_l;
        int          strobes;
        bit          mapped_legal;
        bit          exp_err;
        bit          got_done;
        bit          ok;
        logic [31:0] sdata [NS];
        logic [31:0] exp_rd_data;
        logic [NS-1:0] exp_cs, exp_rdv, exp_wrv, ack;
        logic [20:0] addr;

        mapped_legal = (cmd == 0 || cmd == 1) && slot < NS;
        exp_err      = !mapped_legal || dly < 0 || dly > TO;
        if (!mapped_legal)          exp_l = 1;
        else if (dly < 0 || dly > TO) exp_l = 2 + TO;
        else                        exp_l = 2 + dly;

        for (int i = 0; i < NS; i++) begin
            sdata[i] = $urandom;
            bus.slot_rd_data_array[i] = sdata[i];
        end
        addr = 21'($urandom);
        addr[RA+5:RA] = 6'(slot);
        addr[RA-1:0]  = RA'(regn);
        bus.mmio_cs      = 1'b1;
        bus.mmio_rd      = (cmd == 0 || cmd == 2);
        bus.mmio_wr      = (cmd == 1 || cmd == 2);
        bus.mmio_addr    = addr;
        bus.mmio_wr_data = wdata;
        bus.slot_ack_array = '0;
        @(posedge clk);

        got_done = 1'b0;
        strobes  = 0;
        for (int n = 0; n < TO + 8 && !got_done; n++) begin
            @(negedge clk);
            exp_cs = '0; exp_rdv = '0; exp_wrv = '0;
            if (mapped_legal && n == 0) begin
                exp_cs[slot] = 1'b1;
                if (cmd == 0) exp_rdv[slot] = 1'b1;
                else          exp_wrv[slot] = 1'b1;
            end
            if (bus.slot_cs_array != '0) strobes++;
            checks++;
            if (bus.slot_cs_array !== exp_cs || bus.slot_mem_rd_array !== exp_rdv ||
                bus.slot_mem_wr_array !== exp_wrv) begin
                errors++;
                $display("FAIL strobe n=%0d got cs=%h rd=%h wr=%h want cs=%h rd=%h wr=%h",
                         n, bus.slot_cs_array, bus.slot_mem_rd_array, bus.slot_mem_wr_array,
                         exp_cs, exp_rdv, exp_wrv);
            end
            checks++;
            if (bus.mmio_busy !== (n < exp_l)) begin
                errors++;
                $display("FAIL busy n=%0d got %b want %b", n, bus.mmio_busy, (n < exp_l));
            end
            if (mapped_legal) begin
                ok = 1'b1;
                for (int i = 0; i < NS; i++)
                    if (bus.slot_reg_addr_array[i] !== RA'(regn) || bus.slot_wr_data_array[i] !== wdata)
                        ok = 1'b0;
                checks++;
                if (!ok) begin
                    errors++;
                    $display("FAIL broadcast n=%0d got reg=%h data=%h want reg=%h data=%h", n,
                             bus.slot_reg_addr_array[0], bus.slot_wr_data_array[0], RA'(regn), wdata);
                end
            end
            checks++;
            if (bus.mmio_done !== (n == exp_l - 1)) begin
                errors++;
                $display("FAIL done_timing n=%0d got done=%b want latency %0d", n, bus.mmio_done, exp_l);
            end
            if (bus.mmio_done === 1'b1) begin
                got_done = 1'b1;
                if (cmd == 0) model_rd = exp_err ? ERRD : sdata[slot];
                exp_rd_data = model_rd;
                checks++;
                if (bus.mmio_err !== exp_err) begin
                    errors++;
                    $display("FAIL err got %b want %b", bus.mmio_err, exp_err);
                end
                checks++;
                if (bus.mmio_rd_data !== exp_rd_data) begin
                    errors++;
                    $display("FAIL rd_data got %h want %h", bus.mmio_rd_data, exp_rd_data);
                end
            end
            ack = '0;
            if (mapped_legal && dly >= 0 && n >= dly) ack[slot] = 1'b1;
            if (noise) begin
                for (int i = 0; i < NS; i++)
                    if (i != slot && $urandom_range(0, 1) == 1) ack[i] = 1'b1;
            end
            bus.slot_ack_array = ack;
            if (spam) begin
                bus.mmio_cs      = 1'b1;
                bus.mmio_rd      = 1'($urandom_range(0, 1));
                bus.mmio_wr      = ~bus.mmio_rd;
                bus.mmio_addr    = 21'($urandom);
                bus.mmio_addr[RA+5:RA] = 6'($urandom_range(0, NS - 1));
                bus.mmio_wr_data = $urandom;
            end else begin
                bus.mmio_cs = 1'b0;
            end
        end
        if (!got_done) begin
            checks++;
            errors++;
            $display("FAIL no_done got none want latency %0d", exp_l);
        end
        @(negedge clk);
        checks++;
        if (bus.mmio_done !== 1'b0 || bus.mmio_busy !== 1'b0) begin
            errors++;
            $display("FAIL after_done got done=%b busy=%b want 0 0", bus.mmio_done, bus.mmio_busy);
        end
        checks++;
        if (strobes != (mapped_legal ? 1 : 0)) begin
            errors++;
            $display("FAIL strobe_count got %0d want %0d", strobes, (mapped_legal ? 1 : 0));
        end
        bus.mmio_cs = 1'b0;
        bus.mmio_rd = 1'b0;
        bus.mmio_wr = 1'b0;
        bus.slot_ack_array = '0;
    endtask

    task automatic check_reset_outputs(input string tag);
        checks++;
        if (bus.mmio_busy !== 1'b0 || bus.mmio_done !== 1'b0 || bus.mmio_err !== 1'b0 ||
            bus.mmio_rd_data !== '0 || bus.slot_cs_array !== '0 || bus.slot_mem_rd_array !== '0 ||
            bus.slot_mem_wr_array !== '0 || bus.slot_reg_addr_array !== '0 ||
            bus.slot_wr_data_array !== '0) begin
            errors++;
            $display("FAIL %s got busy=%b done=%b err=%b rd=%h cs=%h want all zero", tag,
                     bus.mmio_busy, bus.mmio_done, bus.mmio_err, bus.mmio_rd_data, bus.slot_cs_array);
        end
    endtask

    task automatic test_reset;
        #1 rst = 1'b0;
        #2 check_reset_outputs("reset_values");
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_reset_outputs("after_release");
    endtask

    task automatic test_reset_mid(input int at_n);
        logic [NS-1:0] exp_cs;
        bus.mmio_cs   = 1'b1;
        bus.mmio_rd   = 1'b1;
        bus.mmio_wr   = 1'b0;
        bus.mmio_addr = '0;
        bus.mmio_addr[RA+5:RA] = 6'd5;
        bus.mmio_addr[RA-1:0]  = RA'(9);
        bus.mmio_wr_data = 32'h0BAD_F00D;
        bus.slot_ack_array = '0;
        @(posedge clk);
        @(negedge clk);
        bus.mmio_cs = 1'b0;
        exp_cs = '0;
        exp_cs[5] = 1'b1;
        checks++;
        if (bus.slot_cs_array !== exp_cs) begin
            errors++;
            $display("FAIL reset_pre_strobe got %h want %h", bus.slot_cs_array, exp_cs);
        end
        repeat (at_n) @(negedge clk);
        #2 rst = 1'b0;
        #1 check_reset_outputs("reset_mid");
        model_rd = '0;
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            checks++;
            if (bus.mmio_done !== 1'b0 || bus.mmio_busy !== 1'b0 || bus.slot_cs_array !== '0) begin
                errors++;
                $display("FAIL reset_discard cyc=%0d got done=%b busy=%b want 0 0", i,
                         bus.mmio_done, bus.mmio_busy);
            end
        end
    endtask

    task automatic test_ignored;
        bus.mmio_cs = 1'b1;
        bus.mmio_rd = 1'b0;
        bus.mmio_wr = 1'b0;
        bus.mmio_addr = 21'($urandom);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (bus.mmio_busy !== 1'b0 || bus.mmio_done !== 1'b0 || bus.slot_cs_array !== '0) begin
                errors++;
                $display("FAIL ignored cyc=%0d got busy=%b done=%b want 0 0", i, bus.mmio_busy, bus.mmio_done);
            end
        end
        bus.mmio_cs = 1'b0;
    endtask

    task automatic test_zero_wait_read;
        txn(0, 3, 7, $urandom, 0, 1'b0, 1'b0);
        txn(0, 11, 31, $urandom, 0, 1'b0, 1'b0);
    endtask

    task automatic test_wait_write;
        txn(1, 10, 2, 32'hA5A5_0001, 4, 1'b0, 1'b0);
    endtask

    task automatic test_timeout;
        txn(0, 2, 4, $urandom, -1, 1'b0, 1'b0);
        txn(0, 2, 5, $urandom, 1, 1'b0, 1'b0);
        txn(0, 6, 1, $urandom, TO, 1'b0, 1'b0);
        txn(1, 7, 1, $urandom, -1, 1'b0, 1'b0);
    endtask

    task automatic test_unmapped_illegal;
        txn(0, 12, 3, $urandom, 0, 1'b0, 1'b0);
        txn(1, 63, 3, $urandom, 0, 1'b0, 1'b0);
        txn(0, 4, 3, $urandom, 0, 1'b0, 1'b0);
        txn(2, 4, 3, $urandom, 0, 1'b0, 1'b0);
    endtask

    task automatic test_busy;
        txn(0, 8, 6, $urandom, 5, 1'b1, 1'b1);
        txn(1, 1, 6, $urandom, 0, 1'b1, 1'b1);
    endtask

    task automatic test_back_to_back;
        int cmd, slot, dly, r;
        for (int t = 0; t < 40; t++) begin
            r = $urandom_range(0, 9);
            cmd  = (r < 5) ? 0 : (r < 9) ? 1 : 2;
            slot = ($urandom_range(0, 9) == 0) ? 63 : $urandom_range(0, 15);
            r = $urandom_range(0, 7);
            dly  = (r == 0) ? -1 : (r == 1) ? TO : $urandom_range(0, 6);
            txn(cmd, slot, $urandom_range(0, 31), $urandom, dly, 1'($urandom_range(0, 1)), 1'b1);
        end
    endtask

    initial begin
        bus.mmio_cs = 1'b0;
        bus.mmio_rd = 1'b0;
        bus.mmio_wr = 1'b0;
        bus.mmio_addr = '0;
        bus.mmio_wr_data = '0;
        bus.slot_rd_data_array = '0;
        bus.slot_ack_array = '0;
        test_reset();
        test_zero_wait_read();
        test_wait_write();
        test_timeout();
        test_unmapped_illegal();
        test_ignored();
        test_busy();
        test_reset_mid(0);
        test_zero_wait_read();
        test_reset_mid(3);
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
